// File: rtl/hazard3_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hazard3_bus_arbiter
// Purpose  : Shares one pipelined (AHB-Lite-style) bus master port between the
//            instruction-fetch requester (i_*) and the load/store requester
//            (d_*). Sequences address and data phases, tracks the data-phase
//            owner, routes responses back, and bounds fetch starvation.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_addr/i_size         fetch request (i_size: 1 = 32-bit, 0 = 16-bit)
//   i_addr_vld/i_addr_rdy fetch address handshake
//   i_data_vld/err/rdata  fetch response
//   d_addr/d_size/d_write load/store request (d_size: 0 = B, 1 = H, 2 = W)
//   d_addr_vld/d_addr_rdy load/store address handshake
//   d_wdata               store data, held by the LSU through its data phase
//   d_data_vld/err/rdata  load/store response
//   bus_*                 single external bus master port
// ============================================================================
module hazard3_bus_arbiter #(
   parameter int W_ADDR       = 32,
   parameter int W_DATA       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [W_ADDR-1:0] i_addr,
   input  logic              i_size,
   input  logic              i_addr_vld,
   output logic              i_addr_rdy,
   output logic              i_data_vld,
   output logic              i_data_err,
   output logic [W_DATA-1:0] i_rdata,

   input  logic [W_ADDR-1:0] d_addr,
   input  logic [1:0]        d_size,
   input  logic              d_write,
   input  logic              d_addr_vld,
   output logic              d_addr_rdy,
   input  logic [W_DATA-1:0] d_wdata,
   output logic              d_data_vld,
   output logic              d_data_err,
   output logic [W_DATA-1:0] d_rdata,

   output logic [W_ADDR-1:0] bus_addr,
   output logic [1:0]        bus_size,
   output logic              bus_write,
   output logic              bus_addr_vld,
   input  logic              bus_ready,
   input  logic              bus_err,
   input  logic [W_DATA-1:0] bus_rdata,
   output logic [W_DATA-1:0] bus_wdata
);

   localparam int CTR_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CTR_W-1:0] STARVE_MAX = CTR_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   owner_t            owner;
   owner_t            aph_owner;
   owner_t            dph_owner;
   logic              aph_lock;
   logic              dph_write;
   logic [CTR_W-1:0]  starve_ctr;
   logic              data_done;

   // Address-phase owner. Deliberately independent of bus_ready so the
   // address phase never combinationally depends on the slave's hready.
   // Reset forces NONE so nothing is presented while rst is high.
   always_comb begin
      owner = OWN_NONE;
      if (rst) begin
         owner = OWN_NONE;
      end else if (aph_lock) begin
         owner = aph_owner;
      end else if (i_addr_vld && d_addr_vld) begin
         owner = (starve_ctr == STARVE_MAX) ? OWN_I : OWN_D;
      end else if (i_addr_vld) begin
         owner = OWN_I;
      end else if (d_addr_vld) begin
         owner = OWN_D;
      end
   end

   // Address-phase mux. Requesters hold their request stable until accepted,
   // so muxing from the (locked) owner keeps the bus outputs stable too.
   always_comb begin
      bus_addr  = '0;
      bus_size  = 2'd0;
      bus_write = 1'b0;
      case (owner)
         OWN_I: begin
            bus_addr  = i_addr;
            bus_size  = {1'b0, i_size} + 2'd1;
            bus_write = 1'b0;
         end
         OWN_D: begin
            bus_addr  = d_addr;
            bus_size  = d_size;
            bus_write = d_write;
         end
         default: begin
            bus_addr  = '0;
            bus_size  = 2'd0;
            bus_write = 1'b0;
         end
      endcase
   end

   assign bus_addr_vld = (owner != OWN_NONE);
   assign i_addr_rdy   = (owner == OWN_I) && bus_ready;
   assign d_addr_rdy   = (owner == OWN_D) && bus_ready;

   // A data phase in flight at reset is abandoned: no response is reported.
   assign data_done  = bus_ready && !rst;
   assign i_data_vld = data_done && (dph_owner == OWN_I);
   assign d_data_vld = data_done && (dph_owner == OWN_D);
   assign i_data_err = i_data_vld && bus_err;
   assign d_data_err = d_data_vld && bus_err;
   assign i_rdata    = i_data_vld ? bus_rdata : '0;
   assign d_rdata    = d_data_vld ? bus_rdata : '0;

   assign bus_wdata  = ((dph_owner == OWN_D) && dph_write) ? d_wdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         aph_lock   <= 1'b0;
         aph_owner  <= OWN_NONE;
         dph_owner  <= OWN_NONE;
         dph_write  <= 1'b0;
         starve_ctr <= '0;
      end else begin
         // A presented but unaccepted address phase pins the owner.
         aph_lock  <= bus_addr_vld && !bus_ready;
         aph_owner <= owner;

         if (bus_ready) begin
            dph_owner <= owner;
            dph_write <= (owner == OWN_D) && d_write;
         end

         // Clearing wins over the lock hold so a forced fetch grant that
         // stalls still returns the counter to zero once it is accepted.
         // Increments only on a fresh (unlocked) data-side win.
         if (!i_addr_vld || i_addr_rdy) begin
            starve_ctr <= '0;
         end else if (!aph_lock && (owner == OWN_D) && (starve_ctr != STARVE_MAX)) begin
            starve_ctr <= starve_ctr + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard3_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard3_bus_arbiter
// Purpose  : Directed self-checking bench for hazard3_bus_arbiter. Inputs are
//            driven 1 time unit after the rising edge; outputs are sampled on
//            the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard3_bus_arbiter;

   logic        clk;
   logic        rst;
   logic [31:0] i_addr;
   logic        i_size;
   logic        i_addr_vld;
   logic        i_addr_rdy;
   logic        i_data_vld;
   logic        i_data_err;
   logic [31:0] i_rdata;
   logic [31:0] d_addr;
   logic [1:0]  d_size;
   logic        d_write;
   logic        d_addr_vld;
   logic        d_addr_rdy;
   logic [31:0] d_wdata;
   logic        d_data_vld;
   logic        d_data_err;
   logic [31:0] d_rdata;
   logic [31:0] bus_addr;
   logic [1:0]  bus_size;
   logic        bus_write;
   logic        bus_addr_vld;
   logic        bus_ready;
   logic        bus_err;
   logic [31:0] bus_rdata;
   logic [31:0] bus_wdata;

   int errors;
   int checks;

   hazard3_bus_arbiter #(
      .W_ADDR       (32),
      .W_DATA       (32),
      .STARVE_LIMIT (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_addr       (i_addr),
      .i_size       (i_size),
      .i_addr_vld   (i_addr_vld),
      .i_addr_rdy   (i_addr_rdy),
      .i_data_vld   (i_data_vld),
      .i_data_err   (i_data_err),
      .i_rdata      (i_rdata),
      .d_addr       (d_addr),
      .d_size       (d_size),
      .d_write      (d_write),
      .d_addr_vld   (d_addr_vld),
      .d_addr_rdy   (d_addr_rdy),
      .d_wdata      (d_wdata),
      .d_data_vld   (d_data_vld),
      .d_data_err   (d_data_err),
      .d_rdata      (d_rdata),
      .bus_addr     (bus_addr),
      .bus_size     (bus_size),
      .bus_write    (bus_write),
      .bus_addr_vld (bus_addr_vld),
      .bus_ready    (bus_ready),
      .bus_err      (bus_err),
      .bus_rdata    (bus_rdata),
      .bus_wdata    (bus_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      @(negedge clk);
      checks++;
      if (bus_addr_vld !== 1'b0 || i_addr_rdy !== 1'b0 || d_addr_rdy !== 1'b0) begin
         errors++;
         $display("FAIL reset_aph: got vld=%b irdy=%b drdy=%b want 0 0 0", bus_addr_vld, i_addr_rdy, d_addr_rdy);
      end
      checks++;
      if (i_data_vld !== 1'b0 || d_data_vld !== 1'b0 || bus_wdata !== 32'h0 || bus_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_dph: got ivld=%b dvld=%b wdata=%h addr=%h want 0", i_data_vld, d_data_vld, bus_wdata, bus_addr);
      end
      step();
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      i_addr = 32'h100; i_size = 1'b1; i_addr_vld = 1'b1; bus_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_addr !== 32'h100 || bus_size !== 2'd2 || bus_write !== 1'b0 || bus_addr_vld !== 1'b1) begin
         errors++;
         $display("FAIL fetch_aph: got addr=%h size=%0d wr=%b vld=%b want 100 2 0 1", bus_addr, bus_size, bus_write, bus_addr_vld);
      end
      checks++;
      if (i_addr_rdy !== 1'b1 || d_addr_rdy !== 1'b0) begin
         errors++;
         $display("FAIL fetch_rdy: got irdy=%b drdy=%b want 1 0", i_addr_rdy, d_addr_rdy);
      end
      step();
      i_addr_vld = 1'b0; bus_rdata = 32'hDEADBEEF;
      @(negedge clk);
      checks++;
      if (i_data_vld !== 1'b1 || i_rdata !== 32'hDEADBEEF || i_data_err !== 1'b0 || d_data_vld !== 1'b0) begin
         errors++;
         $display("FAIL fetch_dph: got ivld=%b rdata=%h err=%b dvld=%b want 1 deadbeef 0 0", i_data_vld, i_rdata, i_data_err, d_data_vld);
      end
      checks++;
      if (bus_addr_vld !== 1'b0) begin
         errors++;
         $display("FAIL fetch_idle: got bus_addr_vld=%b want 0", bus_addr_vld);
      end
      step();
      @(negedge clk);
      checks++;
      if (i_data_vld !== 1'b0) begin
         errors++;
         $display("FAIL fetch_once: got i_data_vld=%b want 0", i_data_vld);
      end
   endtask

   task automatic test_both_request();
      step();
      i_addr = 32'h300; i_size = 1'b0; i_addr_vld = 1'b1;
      d_addr = 32'h400; d_size = 2'd2; d_write = 1'b1; d_wdata = 32'h12345678; d_addr_vld = 1'b1;
      bus_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (d_addr_rdy !== 1'b1 || i_addr_rdy !== 1'b0 || bus_addr !== 32'h400 || bus_write !== 1'b1 || bus_size !== 2'd2) begin
         errors++;
         $display("FAIL both_grant_d: got drdy=%b irdy=%b addr=%h wr=%b size=%0d want 1 0 400 1 2", d_addr_rdy, i_addr_rdy, bus_addr, bus_write, bus_size);
      end
      step();
      d_addr_vld = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_wdata !== 32'h12345678 || d_data_vld !== 1'b1 || d_data_err !== 1'b0 || i_data_vld !== 1'b0) begin
         errors++;
         $display("FAIL both_store_dph: got wdata=%h dvld=%b derr=%b ivld=%b want 12345678 1 0 0", bus_wdata, d_data_vld, d_data_err, i_data_vld);
      end
      checks++;
      if (i_addr_rdy !== 1'b1 || bus_addr !== 32'h300 || bus_size !== 2'd1 || bus_write !== 1'b0) begin
         errors++;
         $display("FAIL both_then_i: got irdy=%b addr=%h size=%0d wr=%b want 1 300 1 0", i_addr_rdy, bus_addr, bus_size, bus_write);
      end
      step();
      i_addr_vld = 1'b0; bus_rdata = 32'h0BADF00D;
      @(negedge clk);
      checks++;
      if (i_data_vld !== 1'b1 || i_rdata !== 32'h0BADF00D || d_data_vld !== 1'b0 || bus_wdata !== 32'h0) begin
         errors++;
         $display("FAIL both_i_dph: got ivld=%b rdata=%h dvld=%b wdata=%h want 1 0badf00d 0 0", i_data_vld, i_rdata, d_data_vld, bus_wdata);
      end
      d_write = 1'b0;
   endtask

   task automatic test_stall();
      step();
      i_addr = 32'h200; i_size = 1'b1; i_addr_vld = 1'b1; bus_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_addr !== 32'h200 || bus_addr_vld !== 1'b1 || i_addr_rdy !== 1'b0) begin
         errors++;
         $display("FAIL stall_c1: got addr=%h vld=%b irdy=%b want 200 1 0", bus_addr, bus_addr_vld, i_addr_rdy);
      end
      step();
      d_addr = 32'h500; d_size = 2'd0; d_write = 1'b0; d_addr_vld = 1'b1;
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if (bus_addr !== 32'h200 || bus_size !== 2'd2 || i_addr_rdy !== 1'b0 || d_addr_rdy !== 1'b0) begin
            errors++;
            $display("FAIL stall_c%0d: got addr=%h size=%0d irdy=%b drdy=%b want 200 2 0 0", c, bus_addr, bus_size, i_addr_rdy, d_addr_rdy);
         end
         step();
      end
      bus_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_addr !== 32'h200 || i_addr_rdy !== 1'b1 || d_addr_rdy !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got addr=%h irdy=%b drdy=%b want 200 1 0", bus_addr, i_addr_rdy, d_addr_rdy);
      end
      step();
      i_addr_vld = 1'b0; bus_rdata = 32'h11112222;
      @(negedge clk);
      checks++;
      if (d_addr_rdy !== 1'b1 || bus_addr !== 32'h500 || bus_size !== 2'd0 || i_data_vld !== 1'b1 || i_rdata !== 32'h11112222) begin
         errors++;
         $display("FAIL stall_d_next: got drdy=%b addr=%h size=%0d ivld=%b rdata=%h want 1 500 0 1 11112222", d_addr_rdy, bus_addr, bus_size, i_data_vld, i_rdata);
      end
      step();
      d_addr_vld = 1'b0; bus_rdata = 32'hCAFE0001;
      @(negedge clk);
      checks++;
      if (d_data_vld !== 1'b1 || d_rdata !== 32'hCAFE0001 || i_data_vld !== 1'b0 || bus_wdata !== 32'h0) begin
         errors++;
         $display("FAIL stall_load_dph: got dvld=%b rdata=%h ivld=%b wdata=%h want 1 cafe0001 0 0", d_data_vld, d_rdata, i_data_vld, bus_wdata);
      end
   endtask

   task automatic test_error();
      step();
      d_addr = 32'h600; d_size = 2'd2; d_write = 1'b0; d_addr_vld = 1'b1; bus_ready = 1'b1;
      step();
      d_addr_vld = 1'b0; bus_err = 1'b1;
      @(negedge clk);
      checks++;
      if (d_data_vld !== 1'b1 || d_data_err !== 1'b1 || i_data_vld !== 1'b0 || i_data_err !== 1'b0) begin
         errors++;
         $display("FAIL error_load: got dvld=%b derr=%b ivld=%b ierr=%b want 1 1 0 0", d_data_vld, d_data_err, i_data_vld, i_data_err);
      end
      step();
      @(negedge clk);
      checks++;
      if (d_data_vld !== 1'b0 || d_data_err !== 1'b0) begin
         errors++;
         $display("FAIL error_once: got dvld=%b derr=%b want 0 0", d_data_vld, d_data_err);
      end
      bus_err = 1'b0;
   endtask

   task automatic test_starvation();
      logic [5:0] exp_i;
      exp_i = 6'b010000;   // bit k: fetch granted in cycle k+1
      step();
      i_addr = 32'h900; i_size = 1'b1; i_addr_vld = 1'b1;
      d_addr = 32'hA00; d_size = 2'd2; d_write = 1'b0; d_addr_vld = 1'b1;
      bus_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (i_addr_rdy !== exp_i[k] || d_addr_rdy !== !exp_i[k]) begin
            errors++;
            $display("FAIL starve_cycle%0d: got irdy=%b drdy=%b want %b %b", k + 1, i_addr_rdy, d_addr_rdy, exp_i[k], !exp_i[k]);
         end
         step();
      end
      i_addr_vld = 1'b0; d_addr_vld = 1'b0;
   endtask

   task automatic test_reset_mid();
      step();
      i_addr = 32'h700; i_size = 1'b1; i_addr_vld = 1'b1; bus_ready = 1'b1;
      step();
      i_addr_vld = 1'b0; bus_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (i_data_vld !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_stall: got i_data_vld=%b want 0", i_data_vld);
      end
      step();
      rst = 1'b1; bus_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (i_data_vld !== 1'b0 || bus_addr_vld !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_during: got ivld=%b vld=%b want 0 0", i_data_vld, bus_addr_vld);
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (i_data_vld !== 1'b0 || d_data_vld !== 1'b0 || bus_addr_vld !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_after: got ivld=%b dvld=%b vld=%b want 0 0 0", i_data_vld, d_data_vld, bus_addr_vld);
      end
      step();
      i_addr = 32'h800; i_size = 1'b0; i_addr_vld = 1'b1;
      @(negedge clk);
      checks++;
      if (i_addr_rdy !== 1'b1 || bus_addr !== 32'h800 || bus_size !== 2'd1) begin
         errors++;
         $display("FAIL rstmid_refetch: got irdy=%b addr=%h size=%0d want 1 800 1", i_addr_rdy, bus_addr, bus_size);
      end
      step();
      i_addr_vld = 1'b0; bus_rdata = 32'h55AA55AA;
      @(negedge clk);
      checks++;
      if (i_data_vld !== 1'b1 || i_rdata !== 32'h55AA55AA) begin
         errors++;
         $display("FAIL rstmid_redata: got ivld=%b rdata=%h want 1 55aa55aa", i_data_vld, i_rdata);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      i_addr = '0; i_size = 1'b0; i_addr_vld = 1'b0;
      d_addr = '0; d_size = 2'd0; d_write = 1'b0; d_addr_vld = 1'b0; d_wdata = '0;
      bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = '0;

      test_reset();
      test_fetch();
      test_both_request();
      test_stall();
      test_error();
      test_starvation();
      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
